// File: rtl/motor_index_counter.sv
// Motor index mark counter: synchronises and debounces the photo-interrupter pulse, times each
// revolution, and tracks lock/stall health with glitch rejection.
module motor_index_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    parameter int MIN_PERIOD  = 1_000_000,
    parameter int MAX_PERIOD  = 50_000_000,
    parameter int TOL_SHIFT   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        zero_sig_in,
    output logic [31:0] cycle_cnt,
    output logic [31:0] period,
    output logic        period_valid,
    output logic [15:0] rev_cnt,
    output logic        motor_ok,
    output logic        motor_stall,
    output logic [7:0]  glitch_cnt
);

    localparam int              DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [31:0]     SAT     = 32'(MAX_PERIOD - 1);
    localparam logic [32:0]     MIN_V   = 33'(MIN_PERIOD);

    typedef enum logic [1:0] {IDLE, RUN, LOCKED, STALL} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   filt;
    logic [DB_W-1:0]        db_cnt;
    logic                   index_evt;
    logic [31:0]            prev_period;
    logic [32:0]            cnt_inc;
    logic [32:0]            diff;
    logic [32:0]            tol;
    logic                   in_tol;
    logic                   accept;
    logic                   reject;
    logic                   report;

    assign sync_out = sync[SYNC_STAGES-1];

    // The filtered level only follows the synchroniser after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            filt      <= 1'b0;
            db_cnt    <= '0;
            index_evt <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], zero_sig_in};
            index_evt <= 1'b0;
            if (sync_out != filt) begin
                if (db_cnt == DB_LAST) begin
                    filt      <= sync_out;
                    db_cnt    <= '0;
                    index_evt <= sync_out;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        cnt_inc    = {1'b0, cycle_cnt} + 33'd1;
        diff       = (cnt_inc >= {1'b0, prev_period}) ? cnt_inc - {1'b0, prev_period}
                                                      : {1'b0, prev_period} - cnt_inc;
        tol        = {1'b0, prev_period >> TOL_SHIFT};
        in_tol     = (prev_period != '0) && (diff <= tol);
        accept     = 1'b0;
        reject     = 1'b0;
        report     = 1'b0;
        state_next = state;
        case (state)
            IDLE, STALL: begin
                if (index_evt) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN, LOCKED: begin
                // An index on the saturation cycle is still a revolution, so it beats the stall check.
                if (index_evt && (cnt_inc < MIN_V)) begin
                    reject = 1'b1;
                end else if (index_evt) begin
                    accept     = 1'b1;
                    report     = 1'b1;
                    state_next = in_tol ? LOCKED : RUN;
                end else if (cycle_cnt == SAT) begin
                    state_next = STALL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            rev_cnt      <= '0;
            glitch_cnt   <= '0;
            prev_period  <= '0;
        end else begin
            period_valid <= report;
            if (accept)                cycle_cnt <= '0;
            else if (cycle_cnt != SAT) cycle_cnt <= cycle_cnt + 32'd1;
            if (report) begin
                period      <= cnt_inc[31:0];
                prev_period <= cnt_inc[31:0];
                rev_cnt     <= rev_cnt + 16'd1;
            end else if (accept) begin
                prev_period <= '0;
            end
            if (reject && (glitch_cnt != 8'hFF)) glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    assign motor_ok    = (state == LOCKED);
    assign motor_stall = (state == STALL);

endmodule

// File: tb/tb_motor_index_counter.sv
// Bench for motor_index_counter: timestamp-based revolution model checked every cycle, a
// scenario table, hand-written stall/saturation sequences and randomized pulse trains.
module tb_motor_index_counter;

    localparam int MIN_P = 100;
    localparam int MAX_P = 10000;
    localparam int TOL   = 4;
    localparam int DEB   = 4;
    localparam int LAT   = 7;   // pulse start to registered output update

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zero_sig_in = 1'b0;
    logic [31:0] cycle_cnt;
    logic [31:0] period;
    logic        period_valid;
    logic [15:0] rev_cnt;
    logic        motor_ok;
    logic        motor_stall;
    logic [7:0]  glitch_cnt;

    motor_index_counter #(
        .SYNC_STAGES(2), .DEBOUNCE(DEB), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P), .TOL_SHIFT(TOL)
    ) dut (
        .clk(clk), .rst(rst), .zero_sig_in(zero_sig_in), .cycle_cnt(cycle_cnt), .period(period),
        .period_valid(period_valid), .rev_cnt(rev_cnt), .motor_ok(motor_ok),
        .motor_stall(motor_stall), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    int unsigned m_prev = 0;
    int unsigned m_period = 0;
    int unsigned m_rev = 0;
    int unsigned m_glitch = 0;
    bit          m_pv = 1'b0;
    int          mstate = 0;   // 0 idle, 1 run, 2 locked, 3 stall
    int unsigned evq[$];

    typedef struct {
        int gap;
        int width;
        bit pv;
        int per;
        bit ok;
        int rev;
        int gl;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_vec(input string name, input logic [90:0] act, input logic [90:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0; t0 = 0; m_prev = 0; m_period = 0; m_rev = 0; m_glitch = 0; m_pv = 1'b0;
        mstate = 0;
        evq.delete();
    endtask

    // Revolution bookkeeping by timestamps: elapsed = now - time of last accepted index.
    task automatic model_update();
        int unsigned el;
        int unsigned d;
        el   = cyc - t0;
        m_pv = 1'b0;
        if (evq.size() != 0 && evq[0] == cyc) begin
            evq.delete(0);
            if (mstate == 0 || mstate == 3) begin
                mstate = 1; t0 = cyc; m_prev = 0;
            end else if (el < MIN_P) begin
                if (m_glitch < 255) m_glitch++;
            end else begin
                m_period = el;
                m_pv     = 1'b1;
                m_rev    = (m_rev + 1) % 65536;
                d        = (el > m_prev) ? el - m_prev : m_prev - el;
                mstate   = (m_prev != 0 && d <= (m_prev >> TOL)) ? 2 : 1;
                m_prev   = el;
                t0       = cyc;
            end
        end else if ((mstate == 1 || mstate == 2) && el >= MAX_P) begin
            mstate = 3;
        end
    endtask

    task automatic step();
        int unsigned el;
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        el = cyc - t0;
        if (el > MAX_P - 1) el = MAX_P - 1;
        check_vec("model",
                  {cycle_cnt, period, period_valid, rev_cnt, motor_ok, motor_stall, glitch_cnt},
                  {el, m_period, m_pv, m_rev[15:0], mstate == 2, mstate == 3, m_glitch[7:0]});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic idle_until(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic pulse(input int w);
        zero_sig_in = 1'b1;
        if (w >= DEB) evq.push_back(cyc + LAT);
        idle(w);
        zero_sig_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_vec("reset_outputs",
                  {cycle_cnt, period, period_valid, rev_cnt, motor_ok, motor_stall, glitch_cnt}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int unsigned s;
        int unsigned last_start;
        tbl[0]  = '{10,   5, 1'b0, 0,    1'b0, 0, 0};
        tbl[1]  = '{1000, 5, 1'b1, 1000, 1'b0, 1, 0};
        tbl[2]  = '{1000, 5, 1'b1, 1000, 1'b1, 2, 0};
        tbl[3]  = '{1000, 5, 1'b1, 1000, 1'b1, 3, 0};
        tbl[4]  = '{1000, 5, 1'b1, 1000, 1'b1, 4, 0};
        tbl[5]  = '{50,   5, 1'b0, 1000, 1'b1, 4, 1};
        tbl[6]  = '{950,  5, 1'b1, 1000, 1'b1, 5, 1};
        tbl[7]  = '{500,  2, 1'b0, 1000, 1'b1, 5, 1};
        tbl[8]  = '{500,  5, 1'b1, 1000, 1'b1, 6, 1};
        tbl[9]  = '{1200, 5, 1'b1, 1200, 1'b0, 7, 1};
        tbl[10] = '{1200, 5, 1'b1, 1200, 1'b1, 8, 1};

        repeat (3) @(posedge clk);
        do_reset();

        // Idle with no index: only cycle_cnt moves, saturating.
        idle(20000);
        check("idle_cycle_cnt", cycle_cnt, 32'd9999);
        check("idle_stall", 32'(motor_stall), 32'd0);

        last_start = cyc;
        for (int i = 0; i < 11; i++) begin
            s = last_start + tbl[i].gap;
            idle_until(s);
            last_start = cyc;
            pulse(tbl[i].width);
            idle_until(last_start + LAT);
            check($sformatf("tbl%0d_pv", i),     32'(period_valid), 32'(tbl[i].pv));
            check($sformatf("tbl%0d_period", i), period,            32'(tbl[i].per));
            check($sformatf("tbl%0d_ok", i),     32'(motor_ok),     32'(tbl[i].ok));
            check($sformatf("tbl%0d_rev", i),    32'(rev_cnt),      32'(tbl[i].rev));
            check($sformatf("tbl%0d_glitch", i), 32'(glitch_cnt),   32'(tbl[i].gl));
            if (tbl[i].pv) begin
                step();
                check($sformatf("tbl%0d_pv_end", i), 32'(period_valid), 32'd0);
            end
        end

        // Stop pulses: stall exactly MAX_P cycles after the last accepted index.
        for (int k = 0; k < 11000 && !motor_stall; k++) step();
        check("stall_time", cyc, last_start + LAT + MAX_P);
        check("stall_flag", 32'(motor_stall), 32'd1);
        check("stall_ok", 32'(motor_ok), 32'd0);
        check("stall_cnt", cycle_cnt, 32'd9999);

        idle(5);
        s = cyc;
        pulse(5);
        idle_until(s + LAT);
        check("resume1_pv", 32'(period_valid), 32'd0);
        check("resume1_stall", 32'(motor_stall), 32'd0);
        check("resume1_cnt", cycle_cnt, 32'd0);
        idle_until(s + 1000);
        s = cyc;
        pulse(5);
        idle_until(s + LAT);
        check("resume2_pv", 32'(period_valid), 32'd1);
        check("resume2_period", period, 32'd1000);
        check("resume2_ok", 32'(motor_ok), 32'd0);
        check("resume2_rev", 32'(rev_cnt), 32'd9);
        idle_until(s + 1000);
        s = cyc;
        pulse(5);
        idle_until(s + LAT);
        check("resume3_ok", 32'(motor_ok), 32'd1);
        check("resume3_rev", 32'(rev_cnt), 32'd10);

        // Index landing on the saturation cycle is accepted instead of stalling.
        idle_until(s + MAX_P);
        s = cyc;
        pulse(5);
        idle_until(s + LAT - 1);
        check("coinc_pre_cnt", cycle_cnt, 32'd9999);
        check("coinc_pre_stall", 32'(motor_stall), 32'd0);
        step();
        check("coinc_pv", 32'(period_valid), 32'd1);
        check("coinc_period", period, 32'd10000);
        check("coinc_stall", 32'(motor_stall), 32'd0);
        check("coinc_rev", 32'(rev_cnt), 32'd11);

        // Five glitches per 120-cycle revolution drive glitch_cnt into saturation.
        idle(200);
        for (int r = 0; r < 56; r++) begin
            pulse(4);
            idle(12);
            for (int g = 0; g < 5; g++) begin
                pulse(4);
                idle(12);
            end
            idle(24);
        end
        check("glitch_sat", 32'(glitch_cnt), 32'd255);
        check("glitch_locked", 32'(motor_ok), 32'd1);

        // Reset mid-revolution.
        pulse(5);
        idle(500);
        do_reset();
        idle(3);
        check("post_reset_cnt", cycle_cnt, 32'd3);

        for (int i = 0; i < 20; i++) begin
            pulse(int'($urandom_range(1, 7)));
            if (i == 10) idle(10100);
            else         idle(int'($urandom_range(12, 600)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
